// File: rtl/i2s_audio_scheduler.sv
// I2S transmit sequencer: serial clock divider, frame FIFO and start/stop/underrun control.
// Optional build macro I2S_SCHED_MUTE_ON_UNDERRUN_EN zeroes the DAC outputs on underrun.
module i2s_audio_scheduler #(
    parameter int BITS       = 16,
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int PRIME      = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [BITS-1:0]               s_left,
    input  logic [BITS-1:0]               s_right,
    input  logic                          sample_pulse,
    output logic                          clk_i2s,
    output logic                          clk_i2s_pulse,
    output logic                          sample_in,
    output logic [BITS-1:0]               DAC_Left,
    output logic [BITS-1:0]               DAC_Right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic [7:0]                    underrun_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(2 * DIV);
    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [CW-1:0] LAST_C = CW'(2 * DIV - 1);
    localparam logic [LW-1:0] PRIME_C = LW'(PRIME);
    localparam logic [LW-1:0] FULL_C  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_SYNC,
        S_RUN,
        S_STOP
    } state_t;

    state_t state_q, state_d;

    logic [2*BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [LW-1:0]     level_q, level_d;
    logic [CW-1:0]     div_q, div_d;
    logic              clk_q, clk_d;
    logic              pulse_q, pulse_d;
    logic              sin_q, sin_d;
    logic [BITS-1:0]   dl_q, dl_d;
    logic [BITS-1:0]   dr_q, dr_d;
    logic [7:0]        und_q, und_d;
    logic              push, pop, running;
    logic [2*BITS-1:0] head;

    assign s_ready = (level_q != FULL_C);
    assign push    = s_valid && s_ready;
    assign head    = mem_q[rd_q];
    assign running = (state_q == S_SYNC) || (state_q == S_RUN) || (state_q == S_STOP);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        dl_d    = dl_q;
        dr_d    = dr_q;
        und_d   = und_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_PRIME;
            end
            S_PRIME: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (level_q >= PRIME_C) begin
                    pop     = 1'b1;
                    dl_d    = head[2*BITS-1:BITS];
                    dr_d    = head[BITS-1:0];
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                state_d = enable ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_STOP;
                    dl_d    = '0;
                    dr_d    = '0;
                end else if (sample_pulse) begin
                    // Level is the registered value: a same-cycle push cannot feed this pop.
                    if (level_q != '0) begin
                        pop  = 1'b1;
                        dl_d = head[2*BITS-1:BITS];
                        dr_d = head[BITS-1:0];
                    end else begin
                        if (und_q != 8'hFF) und_d = und_q + 8'd1;
`ifdef I2S_SCHED_MUTE_ON_UNDERRUN_EN
                        dl_d = '0;
                        dr_d = '0;
`else
                        dl_d = dl_q;
                        dr_d = dr_q;
`endif
                    end
                end
            end
            S_STOP: begin
                if (sample_pulse) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        div_d   = '0;
        clk_d   = 1'b0;
        pulse_d = 1'b0;
        sin_d   = 1'b0;
        if (running) begin
            div_d   = (div_q == LAST_C) ? '0 : div_q + CW'(1);
            clk_d   = (div_q < DIV_C);
            pulse_d = (div_q == '0);
            sin_d   = (div_q == '0) && (state_q == S_SYNC);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            div_q   <= '0;
            clk_q   <= 1'b0;
            pulse_q <= 1'b0;
            sin_q   <= 1'b0;
            dl_q    <= '0;
            dr_q    <= '0;
            und_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            pulse_q <= pulse_d;
            sin_q   <= sin_d;
            dl_q    <= dl_d;
            dr_q    <= dr_d;
            und_q   <= und_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_q] <= {s_left, s_right};
    end

    assign clk_i2s        = clk_q;
    assign clk_i2s_pulse  = pulse_q;
    assign sample_in      = sin_q;
    assign DAC_Left       = dl_q;
    assign DAC_Right      = dr_q;
    assign fifo_level     = level_q;
    assign busy           = (state_q != S_IDLE);
    assign underrun_count = und_q;

endmodule
